// File: rtl/literal_packet_encoder_if.sv
// ---------------------------------------------------------------------------
// literal_packet_encoder_if
//
// Purpose:
//   Bundles the request side and the nibble-stream side of the BITS literal
//   packet encoder, so that the encoder and its user share one connection.
//
// Signals:
//   start       request to encode, accepted only while busy is low
//   version     3-bit packet version, sampled on an accepted start
//   value       64-bit literal value, sampled on an accepted start
//   busy        high from accepted start until the final nibble handshake
//   nibbleOut   current hex nibble of the packet, MSB first
//   nibbleValid nibbleOut holds a valid nibble
//   nibbleReady downstream accepts the nibble when nibbleValid is also high
//   lastNibble  high together with the final nibble of the packet
//   groupCount  number of 5-bit groups (1..16) in the current/last packet
//   done        one-cycle pulse in the cycle after the final handshake
//
// Modports:
//   master  the encoder side (drives busy and the nibble stream)
//   slave   the user side (drives the request and nibbleReady)
// ---------------------------------------------------------------------------
interface literal_packet_encoder_if;

    logic        start;
    logic [2:0]  version;
    logic [63:0] value;
    logic        busy;
    logic [3:0]  nibbleOut;
    logic        nibbleValid;
    logic        nibbleReady;
    logic        lastNibble;
    logic [4:0]  groupCount;
    logic        done;

    modport master (
        input  start,
        input  version,
        input  value,
        input  nibbleReady,
        output busy,
        output nibbleOut,
        output nibbleValid,
        output lastNibble,
        output groupCount,
        output done
    );

    modport slave (
        output start,
        output version,
        output value,
        output nibbleReady,
        input  busy,
        input  nibbleOut,
        input  nibbleValid,
        input  lastNibble,
        input  groupCount,
        input  done
    );

endinterface

// File: rtl/literal_packet_encoder.sv
// ---------------------------------------------------------------------------
// literal_packet_encoder
//
// Purpose:
//   Builds a BITS literal packet (version, type ID, 5-bit groups made of a
//   continuation bit plus a nibble, zero padding to a nibble boundary) from a
//   3-bit version and a 64-bit value, then streams the packet out as hex
//   nibbles, MSB first, under a valid/ready handshake.
//
// Ports:
//   clk     rising-edge clock
//   resetB  asynchronous active-low reset
//   bus     literal_packet_encoder_if.master carrying the request inputs
//           (start, version, value), the nibble stream (nibbleOut,
//           nibbleValid, nibbleReady, lastNibble) and status (busy,
//           groupCount, done)
//
// Flow:
//   IDLE captures the request, LOAD builds the left-aligned frame and the
//   nibble count in one cycle, SEND presents frame[87:84] and shifts the
//   frame left one nibble on every handshake.
// ---------------------------------------------------------------------------
module literal_packet_encoder #(
    parameter logic [2:0] TYPE_ID    = 3'd4,
    parameter int         FRAME_BITS = 88
) (
    input  logic                       clk,
    input  logic                       resetB,
    literal_packet_encoder_if.master   bus
);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SEND
    } state_t;

    state_t                  state_q, state_d;
    logic [2:0]              version_q, version_d;
    logic [63:0]             value_q, value_d;
    logic [FRAME_BITS-1:0]   frame_q, frame_d;
    logic [4:0]              remaining_q, remaining_d;
    logic [4:0]              groupCount_q, groupCount_d;
    logic                    done_q, done_d;

    logic [4:0]              loadGroups;
    logic [6:0]              shiftAmt;
    logic [63:0]             alignedValue;
    logic [79:0]             groupBits;
    logic [6:0]              packetBits;
    logic [4:0]              loadNibbles;
    logic [FRAME_BITS-1:0]   loadFrame;

    // The group count is one more than the index of the highest nonzero
    // nibble. Scanning upward lets the last hit win, and a value of zero
    // falls through to the default of a single group.
    always_comb begin
        loadGroups = 5'd1;
        for (int i = 1; i < 16; i++) begin
            if (value_q[4*i +: 4] != 4'h0) begin
                loadGroups = 5'(i + 1);
            end
        end
    end

    // The value is shifted so that its most significant used nibble sits at
    // bits 63..60. Group slot i (counting from the top of the packet) then
    // always takes nibble slot i, and only the bottom group of the packet
    // carries a zero continuation bit. Unused slots stay zero, which is
    // exactly the padding the packet needs after the last group.
    always_comb begin
        shiftAmt     = {5'd16 - loadGroups, 2'b00};
        alignedValue = value_q << shiftAmt;
        groupBits    = '0;
        for (int i = 0; i < 16; i++) begin
            if (5'(i) < loadGroups) begin
                groupBits[79-5*i -: 5] = {(5'(i) != (loadGroups - 5'd1)),
                                          alignedValue[63-4*i -: 4]};
            end
        end
        loadFrame   = {version_q, TYPE_ID, groupBits, 2'b00};
        packetBits  = 7'd6 + (7'(loadGroups) * 7'd5);
        loadNibbles = 5'((packetBits + 7'd3) >> 2);
    end

    // Next-state and datapath update. Requests are only looked at in IDLE,
    // and nibbleReady only matters in SEND, so stray activity on either in
    // other states has no effect. done is raised for exactly the cycle that
    // follows the handshake of the final nibble.
    always_comb begin
        state_d      = state_q;
        version_d    = version_q;
        value_d      = value_q;
        frame_d      = frame_q;
        remaining_d  = remaining_q;
        groupCount_d = groupCount_q;
        done_d       = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    version_d = bus.version;
                    value_d   = bus.value;
                    state_d   = LOAD;
                end
            end
            LOAD: begin
                frame_d      = loadFrame;
                remaining_d  = loadNibbles;
                groupCount_d = loadGroups;
                state_d      = SEND;
            end
            SEND: begin
                if (bus.nibbleReady) begin
                    frame_d     = {frame_q[FRAME_BITS-5:0], 4'h0};
                    remaining_d = remaining_q - 5'd1;
                    if (remaining_q == 5'd1) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register. Reset clears everything at once, abandoning any packet
    // in flight without a done pulse.
    always_ff @(posedge clk or negedge resetB) begin
        if (!resetB) begin
            state_q      <= IDLE;
            version_q    <= 3'd0;
            value_q      <= 64'd0;
            frame_q      <= '0;
            remaining_q  <= 5'd0;
            groupCount_q <= 5'd0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            version_q    <= version_d;
            value_q      <= value_d;
            frame_q      <= frame_d;
            remaining_q  <= remaining_d;
            groupCount_q <= groupCount_d;
            done_q       <= done_d;
        end
    end

    // Outputs come straight from registered state. The nibble is gated by
    // SEND so that the LOAD cycle never shows leftover frame contents, and it
    // holds steady while stalled because the frame only shifts on handshake.
    always_comb begin
        bus.busy        = (state_q != IDLE);
        bus.nibbleValid = (state_q == SEND);
        bus.nibbleOut   = (state_q == SEND) ? frame_q[FRAME_BITS-1 -: 4] : 4'h0;
        bus.lastNibble  = (state_q == SEND) && (remaining_q == 5'd1);
        bus.groupCount  = groupCount_q;
        bus.done        = done_q;
    end

endmodule

// File: tb/tb_literal_packet_encoder.sv
// ---------------------------------------------------------------------------
// tb_literal_packet_encoder
//
// Purpose:
//   Self-checking bench for literal_packet_encoder. A table of packets with
//   hand-computed nibble streams is applied in a loop, followed by directed
//   sequences for backpressure, back-to-back throughput and reset in the
//   middle of a packet.
// ---------------------------------------------------------------------------
module tb_literal_packet_encoder;

    typedef struct {
        logic [2:0]  ver;
        logic [63:0] val;
        logic [87:0] nib;
        int          nNib;
        logic [4:0]  gc;
    } vec_t;

    logic clk;
    logic resetB;
    int   checkCount;
    int   passCount;
    vec_t vecs [5];

    literal_packet_encoder_if bus ();

    literal_packet_encoder dut (
        .clk    (clk),
        .resetB (resetB),
        .bus    (bus)
    );

    // Free-running 10-unit clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Single comparison point: every check steps checkCount, and passCount
    // only when the actual value matches the expected one.
    task automatic checkOutput(input string name, input logic [87:0] act,
                               input logic [87:0] exp);
        checkCount++;
        if (act !== exp) begin
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end else begin
            passCount++;
        end
    endtask

    // Waits (bounded) for the encoder to be idle, then presents a one-cycle
    // start. Returns at the falling edge of the LOAD cycle.
    task automatic applyStimulus(input logic [2:0] ver, input logic [63:0] val);
        int waitCyc;
        waitCyc = 0;
        while (bus.busy && waitCyc < 100) begin
            @(negedge clk);
            waitCyc++;
        end
        if (bus.busy) begin
            checkOutput("idle_wait", bus.busy, 0);
        end
        @(negedge clk);
        bus.start   = 1'b1;
        bus.version = ver;
        bus.value   = val;
        @(negedge clk);
        bus.start   = 1'b0;
    endtask

    // Runs one full packet and compares every nibble, lastNibble, the hold
    // behaviour while stalled, and the status after the final handshake.
    // With bp set, nibbleReady follows 1,0,0 and spurious starts are pulsed.
    task automatic runPacket(input vec_t v, input bit bp);
        int   idx;
        int   cyc;
        bit   stalled;
        logic [3:0] heldNib;
        logic rdy;
        applyStimulus(v.ver, v.val);
        checkOutput("load_busy", bus.busy, 1);
        checkOutput("load_valid", bus.nibbleValid, 0);
        idx     = 0;
        cyc     = 0;
        stalled = 1'b0;
        heldNib = 4'h0;
        while (idx < v.nNib && cyc < 300) begin
            @(negedge clk);
            cyc++;
            rdy = bp ? ((cyc % 3) == 1) : 1'b1;
            bus.nibbleReady = rdy;
            if (bp) begin
                bus.start   = ((cyc % 4) == 2);
                bus.version = 3'd1;
                bus.value   = 64'hDEAD_BEEF;
            end
            if (bus.nibbleValid) begin
                if (stalled) begin
                    checkOutput("stall_hold", bus.nibbleOut, heldNib);
                end
                if (rdy) begin
                    checkOutput($sformatf("nibble%0d", idx), bus.nibbleOut,
                                v.nib[87-4*idx -: 4]);
                    checkOutput($sformatf("last%0d", idx), bus.lastNibble,
                                (idx == v.nNib - 1));
                    idx++;
                    stalled = 1'b0;
                end else begin
                    stalled = 1'b1;
                    heldNib = bus.nibbleOut;
                end
            end
        end
        if (idx < v.nNib) begin
            checkOutput("stream_timeout", idx, v.nNib);
        end
        @(negedge clk);
        bus.start = 1'b0;
        checkOutput("done_pulse", bus.done, 1);
        checkOutput("done_busy", bus.busy, 0);
        checkOutput("done_valid", bus.nibbleValid, 0);
        checkOutput("done_last", bus.lastNibble, 0);
        checkOutput("group_count", bus.groupCount, v.gc);
        @(negedge clk);
        checkOutput("done_once", bus.done, 0);
        checkOutput("group_keep", bus.groupCount, v.gc);
    endtask

    initial begin
        int cyc;
        int seen;

        checkCount = 0;
        passCount  = 0;

        vecs[0] = '{ver: 3'd6, val: 64'h7E5,
                    nib: {24'hD2FE28, 64'h0}, nNib: 6, gc: 5'd3};
        vecs[1] = '{ver: 3'd0, val: 64'h0,
                    nib: {12'h100, 76'h0}, nNib: 3, gc: 5'd1};
        vecs[2] = '{ver: 3'd7, val: 64'hF,
                    nib: {12'hF1E, 76'h0}, nNib: 3, gc: 5'd1};
        vecs[3] = '{ver: 3'd7, val: 64'hFFFF_FFFF_FFFF_FFFF,
                    nib: 88'hF3_FFFF_FFFF_FFFF_FFFF_FFBC, nNib: 22, gc: 5'd16};
        vecs[4] = '{ver: 3'd1, val: 64'h100,
                    nib: {24'h323000, 64'h0}, nNib: 6, gc: 5'd3};

        resetB          = 1'b0;
        bus.start       = 1'b0;
        bus.version     = 3'd0;
        bus.value       = 64'd0;
        bus.nibbleReady = 1'b0;
        #1;
        checkOutput("rst_busy", bus.busy, 0);
        checkOutput("rst_nibble", bus.nibbleOut, 0);
        checkOutput("rst_valid", bus.nibbleValid, 0);
        checkOutput("rst_last", bus.lastNibble, 0);
        checkOutput("rst_groups", bus.groupCount, 0);
        checkOutput("rst_done", bus.done, 0);
        repeat (3) @(negedge clk);
        resetB = 1'b1;

        $display("[TB] table-driven packets");
        for (int i = 0; i < 5; i++) begin
            runPacket(vecs[i], 1'b0);
        end

        $display("[TB] backpressure on 7E5 packet");
        runPacket(vecs[0], 1'b1);

        // With start and nibbleReady held high, consecutive done pulses are
        // M + 2 cycles apart; the zero-value packet has M = 3.
        $display("[TB] back-to-back throughput");
        @(negedge clk);
        bus.version     = 3'd0;
        bus.value       = 64'd0;
        bus.nibbleReady = 1'b1;
        bus.start       = 1'b1;
        cyc = 0;
        while (!bus.done && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!bus.done && cyc < 100);
        bus.start = 1'b0;
        checkOutput("b2b_period", cyc, 5);
        repeat (8) @(negedge clk);

        // Reset while the third nibble of the longest packet is on the bus.
        $display("[TB] reset mid-packet");
        applyStimulus(3'd7, 64'hFFFF_FFFF_FFFF_FFFF);
        bus.nibbleReady = 1'b1;
        seen = 0;
        cyc  = 0;
        while (seen < 3 && cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (bus.nibbleValid) begin
                seen++;
            end
        end
        checkOutput("mid_third_nibble", bus.nibbleOut, 4'hF);
        #2;
        resetB = 1'b0;
        #1;
        checkOutput("mid_rst_busy", bus.busy, 0);
        checkOutput("mid_rst_valid", bus.nibbleValid, 0);
        checkOutput("mid_rst_nibble", bus.nibbleOut, 0);
        checkOutput("mid_rst_last", bus.lastNibble, 0);
        checkOutput("mid_rst_groups", bus.groupCount, 0);
        checkOutput("mid_rst_done", bus.done, 0);
        @(negedge clk);
        bus.nibbleReady = 1'b0;
        resetB = 1'b1;
        @(negedge clk);
        checkOutput("mid_no_done", bus.done, 0);
        checkOutput("mid_idle", bus.busy, 0);

        $display("[TB] clean packet after reset");
        runPacket(vecs[0], 1'b0);

        $display("[TB] %0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
